// File: rtl/alu_pipe.sv
// Elastic pipelined ALU for the execute stage: combinational compute on the input beat,
// then STAGES valid-tagged register slots with back-pressure, bubble collapsing and flush.
module alu_pipe #(
    parameter int W      = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(W);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_PASSA = 4'd12;
    localparam logic [3:0] OP_PASSB = 4'd13;

    logic [W-1:0]    sum;
    logic [W-1:0]    diff;
    logic [SH_W-1:0] sh;
    logic [W-1:0]    c_res;
    logic            c_ovf;
    logic            c_zero;

    assign sum  = in_a + in_b;
    assign diff = in_a - in_b;
    assign sh   = in_b[SH_W-1:0];

    always_comb begin
        c_res = '0;
        c_ovf = 1'b0;
        case (in_op)
            OP_ADD: begin
                c_res = sum;
                c_ovf = (in_a[W-1] == in_b[W-1]) && (sum[W-1] != in_a[W-1]);
            end
            OP_SUB: begin
                c_res = diff;
                c_ovf = (in_a[W-1] != in_b[W-1]) && (diff[W-1] != in_a[W-1]);
            end
            OP_AND:   c_res = in_a & in_b;
            OP_OR:    c_res = in_a | in_b;
            OP_XOR:   c_res = in_a ^ in_b;
            OP_NOR:   c_res = ~(in_a | in_b);
            OP_SLT:   c_res = {{(W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU:  c_res = {{(W-1){1'b0}}, (in_a < in_b)};
            OP_SLL:   c_res = in_a << sh;
            OP_SRL:   c_res = in_a >> sh;
            OP_SRA:   c_res = $signed(in_a) >>> sh;
            OP_LUI:   c_res = in_b << (W / 2);
            OP_PASSA: c_res = in_a;
            OP_PASSB: c_res = in_b;
            default:  c_res = '0;
        endcase
        c_zero = (c_res == '0);
    end

    // Handshake: a beat moves across any boundary on a rising edge when valid && ready
    // are both high there; valid never depends on ready, ready may depend on downstream ready.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] zero_q;
    logic [STAGES-1:0] ovf_q;
    logic [W-1:0]      res_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [STAGES-1:0] ld;
    logic              full;

    // Slot k may load unless it and every slot downstream of it are valid and the output stalls.
    always_comb begin
        ld   = '0;
        full = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full = full & v_q[j];
            end
            ld[k] = !full || out_ready;
        end
    end

    assign in_ready = ld[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            zero_q <= '0;
            ovf_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                v_q[0] <= in_valid && !flush;
                if (in_valid && !flush) begin
                    res_q[0]  <= c_res;
                    zero_q[0] <= c_zero;
                    ovf_q[0]  <= c_ovf;
                    tag_q[0]  <= in_tag;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_q[k-1] && !flush;
                    if (v_q[k-1] && !flush) begin
                        res_q[k]  <= res_q[k-1];
                        zero_q[k] <= zero_q[k-1];
                        ovf_q[k]  <= ovf_q[k-1];
                        tag_q[k]  <= tag_q[k-1];
                    end
                end
            end
            // A flush only drops validity; data registers keep their last contents.
            if (flush) begin
                v_q <= '0;
            end
        end
    end

    assign out_valid  = v_q[STAGES-1];
    assign out_result = res_q[STAGES-1];
    assign out_zero   = zero_q[STAGES-1];
    assign out_ovf    = ovf_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (W=32, STAGES=2): scenario tasks plus a scoreboard of expected
// {result, zero, ovf, tag} words that a negedge monitor compares against the output slot.
module tb_alu_pipe;

    localparam int W      = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
    localparam int E_W    = W + 2 + TAG_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic             out_zero;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [E_W-1:0] exp_q[$];

    alu_pipe #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference model: signed overflow judged from a wide signed sum rather than sign bits.
    function automatic logic [E_W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [TAG_W-1:0] tag);
        logic [W-1:0] r;
        logic         o;
        longint       sa, sb, s, maxp, minn;
        int           sh;
        r    = '0;
        o    = 1'b0;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxp = 64'sd2147483647;
        minn = -64'sd2147483648;
        sh   = int'(b[4:0]);
        case (op)
            4'd0: begin s = sa + sb; r = a + b; o = (s > maxp) || (s < minn); end
            4'd1: begin s = sa - sb; r = a - b; o = (s > maxp) || (s < minn); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r = (a < b) ? 32'd1 : 32'd0;
            4'd8: r = a << sh;
            4'd9: r = a >> sh;
            4'd10: begin
                r = a >> sh;
                if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
            end
            4'd11: r = {b[15:0], 16'h0000};
            4'd12: r = a;
            4'd13: r = b;
            default: r = '0;
        endcase
        return {r, (r == '0), o, tag};
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL out_unexpected: got result=%h tag=%0d, required no output", out_result, out_tag);
            end else begin
                if ({out_result, out_zero, out_ovf, out_tag} !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL out_data: got r=%h z=%b o=%b t=%0d, required r=%h z=%b o=%b t=%0d",
                             out_result, out_zero, out_ovf, out_tag,
                             exp_q[0][E_W-1 -: W], exp_q[0][TAG_W+1], exp_q[0][TAG_W], exp_q[0][TAG_W-1:0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one beat from posedge+1 until accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            exp_q.push_back(model(op, a, b, tag));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run++;
        if ({out_valid, out_result, out_zero, out_ovf, out_tag} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b r=%h z=%b o=%b t=%0d, required all 0",
                     out_valid, out_result, out_zero, out_ovf, out_tag);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_add_latency();
        out_ready = 1'b1;
        send(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: out_valid=%b one edge after accept, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_result, out_zero, out_ovf, out_tag} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1, 5'd3}) begin
            tests_failed++;
            $display("FAIL add_ovf: got v=%b r=%h z=%b o=%b t=%0d, required v=1 r=80000000 z=0 o=1 t=3",
                     out_valid, out_result, out_zero, out_ovf, out_tag);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(4'd1, 32'd5, 32'd5, 5'd1);
        send(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd2);
        send(4'd10, 32'h8000_0000, 32'h24, 5'd4);
        tests_run++;
        if ({out_valid, out_result, out_tag} !== {1'b1, 32'd1, 5'd2}) begin
            tests_failed++;
            $display("FAIL b2b_slt: got v=%b r=%h t=%0d, required v=1 r=00000001 t=2", out_valid, out_result, out_tag);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_result, out_tag} !== {1'b1, 32'hF800_0000, 5'd4}) begin
            tests_failed++;
            $display("FAIL b2b_sra: got v=%b r=%h t=%0d, required v=1 r=f8000000 t=4", out_valid, out_result, out_tag);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: got out_valid=%b, required 0", out_valid);
        end
        drain();
    endtask

    task automatic test_full_stall();
        logic [W-1:0] a3;
        out_ready = 1'b0;
        send(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5);
        send(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd6);
        a3 = $urandom;
        in_valid = 1'b1;
        in_op = 4'd12;
        in_a = a3;
        in_b = 32'd0;
        in_tag = 5'd7;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_in_ready: got %b with both slots full, required 0", in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_release: got in_ready=%b after out_ready rose, required 1", in_ready);
        end
        @(negedge clk);
        if (in_ready) exp_q.push_back(model(4'd12, a3, 32'd0, 5'd7));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        send(4'd3, 32'h0000_00F0, 32'h0000_000F, 5'd8);
        @(posedge clk);
        #1;
        send(4'd7, 32'd3, 32'hFFFF_FFFF, 5'd9);
        @(negedge clk);
        tests_run++;
        if ({out_valid, in_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bubble_fill: got out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_flush();
        logic [E_W-1:0] e1;
        out_ready = 1'b0;
        e1 = model(4'd8, 32'h0000_0001, 32'h0000_0104, 5'd10);
        send(4'd8, 32'h0000_0001, 32'h0000_0104, 5'd10);
        send(4'd9, 32'h8000_0000, 32'h0000_001F, 5'd11);
        in_valid = 1'b1;
        in_op = 4'd13;
        in_b = 32'h5555_0000;
        in_tag = 5'd12;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        tests_run++;
        if ({out_valid, out_result} !== {1'b0, e1[E_W-1 -: W]}) begin
            tests_failed++;
            $display("FAIL flush_full: got v=%b r=%h, required v=0 r=%h", out_valid, out_result, e1[E_W-1 -: W]);
        end
        out_ready = 1'b1;
        send(4'd5, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd13);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_latency_early: got out_valid=%b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_tag} !== {1'b1, 5'd13}) begin
            tests_failed++;
            $display("FAIL flush_latency: got v=%b t=%0d, required v=1 t=13", out_valid, out_tag);
        end
        drain();
        send(4'd0, 32'd100, 32'd23, 5'd14);
        in_valid = 1'b1;
        in_op = 4'd12;
        in_a = 32'hDEAD_BEEF;
        in_tag = 5'd15;
        flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_drop: got out_valid=%b tag=%0d, required 0", out_valid, out_tag);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(4'd12, 32'h1234_5678, 32'd0, 5'd17);
        send(4'd13, 32'd0, 32'h9ABC_DEF0, 5'd18);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        tests_run++;
        if ({out_valid, out_result, out_zero, out_ovf, out_tag} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: got v=%b r=%h z=%b o=%b t=%0d, required all 0",
                     out_valid, out_result, out_zero, out_ovf, out_tag);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reserved_lui();
        out_ready = 1'b1;
        send(4'd14, $urandom, $urandom, 5'd19);
        @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_result, out_zero, out_ovf} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reserved: got v=%b r=%h z=%b o=%b, required v=1 r=0 z=1 o=0",
                     out_valid, out_result, out_zero, out_ovf);
        end
        send(4'd11, 32'hFFFF_FFFF, 32'h0000_1234, 5'd20);
        @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_result, out_zero} !== {1'b1, 32'h1234_0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL lui: got v=%b r=%h z=%b, required v=1 r=12340000 z=0", out_valid, out_result, out_zero);
        end
        drain();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = $urandom_range(0, 1);
            in_op = 4'($urandom_range(0, 15));
            in_a = pick();
            in_b = pick();
            in_tag = 5'($urandom_range(0, 31));
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b0;
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_full_stall();
        test_bubble();
        test_flush();
        test_reset_midstream();
        test_reserved_lui();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
